// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared constants for the instruction-memory loader: default imem
//   geometry, default release interval, and the loader state encoding.
//   Also provides a sizing helper for the release down-counter.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W         = 12;
  localparam int IMEM_DEPTH          = 4096;
  localparam int INSTR_W             = 32;
  localparam int RELEASE_CYCLES_DFLT = 8;

  // Encodings are fixed so that other processor blocks decoding the
  // loader state see the same values.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FLUSH   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } loader_state_e;

  // Width of a down-counter that must hold the value cycles-1.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Valid/ready word stream carrying the program image into the loader.
//   Signals:
//     in_valid  source has a word on in_data
//     in_ready  loader accepts the word this cycle
//     in_data   instruction word
//     in_last   marks the final word of the program (qualified by in_valid)
//   Modports:
//     master  word source
//     slave   loader
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/imem_loader_release_timer.sv
// load_release_timer
//   Loadable down-counter timing the interval the processor is held in
//   reset after the final imem write.
//   Ports:
//     clock       system clock
//     reset       synchronous, active-high; clears the count
//     load        load load_value (has priority over dec)
//     dec         decrement by one; holds at zero
//     load_value  value loaded on load
//     expired     count is zero
module load_release_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Streams a program into a writable instruction memory over a valid/ready
//   word interface, keeps the processor in reset while loading, waits a
//   settle interval after the final write, then releases the processor.
//   Ports:
//     clock         system clock (same clock as the imem)
//     reset         synchronous, active-high
//     load_start    one-cycle pulse; starts a load at address 0 (IDLE/DONE only)
//     stream        word stream (imem_loader_if.slave)
//     imem_address  registered imem write address
//     imem_data     registered imem write data
//     imem_wren     registered imem write enable
//     proc_reset    registered processor reset; low only in DONE
//     load_done     registered; high only in DONE
//     word_count    words written by the current/last load, saturates at DEPTH
//     overflow_err  sticky: program did not end within DEPTH words
//   DEPTH must equal 2**ADDR_WIDTH.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = IMEM_ADDR_W,
  parameter int DATA_WIDTH     = INSTR_W,
  parameter int DEPTH          = IMEM_DEPTH,
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DFLT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  imem_loader_if.slave          stream,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [DATA_WIDTH-1:0] imem_data,
  output logic                  imem_wren,
  output logic                  proc_reset,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow_err
);

  localparam int TIMER_W = timer_width(RELEASE_CYCLES);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  loader_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_d;
  logic                  ovf_d;
  logic                  wren_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  xfer;
  logic                  timer_load;
  logic                  timer_dec;
  logic                  timer_expired;

  function automatic logic [ADDR_WIDTH:0] count_sat_inc(input logic [ADDR_WIDTH:0] v);
    return (v >= COUNT_MAX) ? COUNT_MAX : v + (ADDR_WIDTH + 1)'(1);
  endfunction

  // Ready is a pure function of state so the source never sees a
  // combinational loop through in_valid.
  assign stream.in_ready = (state_q == LOAD);
  assign xfer            = stream.in_valid && (state_q == LOAD);

  load_release_timer #(
    .CNT_W (TIMER_W)
  ) u_release_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .dec        (timer_dec),
    .load_value (TIMER_W'(RELEASE_CYCLES - 1)),
    .expired    (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = word_count;
    ovf_d      = overflow_err;
    wren_d     = 1'b0;
    addr_d     = imem_address;
    data_d     = imem_data;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end

      LOAD: begin
        if (xfer) begin
          wren_d  = 1'b1;
          addr_d  = ptr_q;
          data_d  = stream.in_data;
          count_d = count_sat_inc(word_count);
          if (ptr_q == LAST_ADDR) begin
            // Top of memory: stop here whether or not the program ended,
            // and leave ptr parked so it can never wrap onto address 0.
            state_d = FLUSH;
            if (!stream.in_last) begin
              ovf_d = 1'b1;
            end
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            if (stream.in_last) begin
              state_d = FLUSH;
            end
          end
        end
      end

      // The final write is on the imem port during this cycle.
      FLUSH: begin
        timer_load = 1'b1;
        state_d    = RELEASE;
      end

      RELEASE: begin
        if (timer_expired) begin
          state_d = DONE;
        end else begin
          timer_dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- registered outputs: derived from the state being entered ----
  always_ff @(posedge clock) begin
    if (reset) begin
      // Any write still pending is dropped; imem keeps partial content.
      ptr_q        <= '0;
      word_count   <= '0;
      overflow_err <= 1'b0;
      imem_wren    <= 1'b0;
      imem_address <= '0;
      imem_data    <= '0;
      proc_reset   <= 1'b1;
      load_done    <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      word_count   <= count_d;
      overflow_err <= ovf_d;
      imem_wren    <= wren_d;
      imem_address <= addr_d;
      imem_data    <= data_d;
      proc_reset   <= (state_d != DONE);
      load_done    <= (state_d == DONE);
    end
  end

endmodule
